// File: rtl/openddr_pkg.sv
// Shared types and defaults for the openddr controller front end.
// arb_req_t is sized by the ARB_*_WIDTH constants; arbiter instances keep their widths equal to these.
package openddr_pkg;
    localparam int ARB_AGE_LIMIT_DEF = 15;
    localparam int ARB_BANK_WIDTH    = 3;
    localparam int ARB_ROW_WIDTH     = 16;
    localparam int ARB_COL_WIDTH     = 10;

    typedef struct packed {
        logic [ARB_BANK_WIDTH-1:0] bank;
        logic [ARB_ROW_WIDTH-1:0]  row;
        logic [ARB_COL_WIDTH-1:0]  col;
        logic                      write;
    } arb_req_t;
endpackage

// File: rtl/openddr_rr_picker.sv
// Rotating priority picker: first set bit of mask at or after ptr, wrapping.
// N must be a power of two so the pointer arithmetic wraps naturally.
module openddr_rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);
    localparam int W = $clog2(N);

    // Offsets are walked high to low so the nearest hit is the last one written.
    always_comb begin
        found = |mask;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[ptr + W'(i)]) idx = ptr + W'(i);
        end
    end
endmodule

// File: rtl/openddr_req_arbiter.sv
// Multi-port request arbiter in front of openddr_scheduler: starved > row hit > round-robin,
// one-entry output register, shadow open-row table, and refresh drain.
module openddr_req_arbiter
    import openddr_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int BANK_WIDTH = ARB_BANK_WIDTH,
    parameter int ROW_WIDTH  = ARB_ROW_WIDTH,
    parameter int COL_WIDTH  = ARB_COL_WIDTH,
    parameter int AGE_LIMIT  = ARB_AGE_LIMIT_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS*BANK_WIDTH-1:0] req_bank,
    input  logic [NUM_PORTS*ROW_WIDTH-1:0]  req_row,
    input  logic [NUM_PORTS*COL_WIDTH-1:0]  req_col,
    input  logic [NUM_PORTS-1:0]            req_write,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BANK_WIDTH-1:0]           out_bank,
    output logic [ROW_WIDTH-1:0]            out_row,
    output logic [COL_WIDTH-1:0]            out_col,
    output logic                            out_write,
    output logic [$clog2(NUM_PORTS)-1:0]    out_port,
    output logic                            out_row_hit,
    input  logic                            ref_req,
    output logic                            ref_ack
);
    localparam int         PW      = $clog2(NUM_PORTS);
    localparam int         NB      = 1 << BANK_WIDTH;
    localparam logic [7:0] AGE_MAX = 8'(AGE_LIMIT);

    arb_req_t             req_view [NUM_PORTS];
    arb_req_t             out_q;
    logic [7:0]           age [NUM_PORTS];
    logic [NB-1:0]        open_valid;
    logic [ROW_WIDTH-1:0] open_row [NB];
    logic [PW-1:0]        rr_ptr;
    logic [NUM_PORTS-1:0] mask_starve;
    logic [NUM_PORTS-1:0] mask_hit;
    logic                 found_starve, found_hit, found_any;
    logic [PW-1:0]        idx_starve, idx_hit, idx_any, winner;
    logic                 arb_en, grant;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign req_view[p] = '{bank:  req_bank[p*BANK_WIDTH +: BANK_WIDTH],
                               row:   req_row[p*ROW_WIDTH +: ROW_WIDTH],
                               col:   req_col[p*COL_WIDTH +: COL_WIDTH],
                               write: req_write[p]};
        assign mask_starve[p] = req_valid[p] && (age[p] == AGE_MAX);
        assign mask_hit[p]    = req_valid[p] && open_valid[req_view[p].bank]
                                && (open_row[req_view[p].bank] == req_view[p].row);
    end

    openddr_rr_picker #(.N(NUM_PORTS)) u_pick_starve (
        .mask(mask_starve), .ptr(rr_ptr), .found(found_starve), .idx(idx_starve)
    );
    openddr_rr_picker #(.N(NUM_PORTS)) u_pick_hit (
        .mask(mask_hit), .ptr(rr_ptr), .found(found_hit), .idx(idx_hit)
    );
    openddr_rr_picker #(.N(NUM_PORTS)) u_pick_any (
        .mask(req_valid), .ptr(rr_ptr), .found(found_any), .idx(idx_any)
    );

    always_comb begin
        if (found_starve)   winner = idx_starve;
        else if (found_hit) winner = idx_hit;
        else                winner = idx_any;
    end

    // rst_n gates the grant so no client sees a handshake while the design is held in reset.
    assign arb_en    = !ref_req && (!out_valid || out_ready);
    assign grant     = rst_n && arb_en && found_any;
    assign req_ready = grant ? (NUM_PORTS'(1) << winner) : '0;
    assign ref_ack   = ref_req && !out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_q       <= '0;
            out_port    <= '0;
            out_row_hit <= 1'b0;
            rr_ptr      <= '0;
            open_valid  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) age[p] <= '0;
            for (int b = 0; b < NB; b++) open_row[b] <= '0;
        end else begin
            if (grant) begin
                out_valid   <= 1'b1;
                out_q       <= req_view[winner];
                out_port    <= winner;
                out_row_hit <= mask_hit[winner];
                rr_ptr      <= winner + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!req_valid[p] || (grant && winner == PW'(p))) age[p] <= '0;
                else if (arb_en && age[p] != AGE_MAX)             age[p] <= age[p] + 8'd1;
            end

            // Refresh precharges every bank, so the shadow table forgets all open rows.
            if (ref_ack) begin
                open_valid <= '0;
            end else if (grant) begin
                open_valid[req_view[winner].bank] <= 1'b1;
                open_row[req_view[winner].bank]   <= req_view[winner].row;
            end
        end
    end

    assign out_bank  = out_q.bank;
    assign out_row   = out_q.row;
    assign out_col   = out_q.col;
    assign out_write = out_q.write;
endmodule

// File: tb/tb_openddr_req_arbiter.sv
// Directed bench for openddr_req_arbiter with a per-cycle behavioural model and literal spot checks.
module tb_openddr_req_arbiter;
    localparam int N  = 4;
    localparam int BW = 3;
    localparam int RW = 16;
    localparam int CW = 10;
    localparam int AL = 3;
    localparam int NB = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_write;
    logic [N*BW-1:0] req_bank;
    logic [N*RW-1:0] req_row;
    logic [N*CW-1:0] req_col;
    logic            out_valid, out_ready, out_write, out_row_hit, ref_req, ref_ack;
    logic [BW-1:0]   out_bank;
    logic [RW-1:0]   out_row;
    logic [CW-1:0]   out_col;
    logic [1:0]      out_port;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    openddr_req_arbiter #(.NUM_PORTS(N), .BANK_WIDTH(BW), .ROW_WIDTH(RW),
                          .COL_WIDTH(CW), .AGE_LIMIT(AL)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_write(req_write),
        .out_valid(out_valid), .out_ready(out_ready), .out_bank(out_bank), .out_row(out_row),
        .out_col(out_col), .out_write(out_write), .out_port(out_port),
        .out_row_hit(out_row_hit), .ref_req(ref_req), .ref_ack(ref_ack)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state after the most recent edge
    bit   m_ov;
    int   m_bank, m_row, m_col, m_wr, m_port, m_hit, m_rr;
    int   m_age [N];
    bit   m_open_v [NB];
    int   m_open_row [NB];
    int   glog [$];
    int   pb [N], pr [N], pc [N];
    bit   pw [N], hitv [N], starv [N];
    int   g, p;
    bit   gr, en;
    logic [N-1:0] erdy;

    task automatic model_reset();
        m_ov = 0; m_bank = 0; m_row = 0; m_col = 0; m_wr = 0; m_port = 0; m_hit = 0; m_rr = 0;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        for (int b = 0; b < NB; b++) begin m_open_v[b] = 0; m_open_row[b] = 0; end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            chk("rst_req_ready", req_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_row", out_row, 0);
            chk("rst_out_port", out_port, 0);
        end else begin
            en = !ref_req && (!m_ov || out_ready);
            for (int i = 0; i < N; i++) begin
                pb[i] = int'(req_bank[i*BW +: BW]);
                pr[i] = int'(req_row[i*RW +: RW]);
                pc[i] = int'(req_col[i*CW +: CW]);
                pw[i] = req_write[i];
                hitv[i]  = req_valid[i] && m_open_v[pb[i]] && (m_open_row[pb[i]] == pr[i]);
                starv[i] = req_valid[i] && (m_age[i] == AL);
            end
            gr = 0; g = 0;
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < N; k++) begin
                    p = (m_rr + k) % N;
                    if (!gr && ((c == 0 && starv[p]) || (c == 1 && hitv[p]) || (c == 2 && req_valid[p]))) begin
                        gr = 1; g = p;
                    end
                end
            gr   = gr && en;
            erdy = gr ? N'(1 << g) : '0;

            chk("req_ready", req_ready, erdy);
            chk("ref_ack", ref_ack, ref_req && !m_ov);
            chk("out_valid", out_valid, m_ov);
            chk("out_bank", out_bank, m_bank);
            chk("out_row", out_row, m_row);
            chk("out_col", out_col, m_col);
            chk("out_write", out_write, m_wr);
            chk("out_port", out_port, m_port);
            chk("out_row_hit", out_row_hit, m_hit);

            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || (gr && g == i)) m_age[i] = 0;
                else if (en && m_age[i] < AL)        m_age[i]++;
            end
            if (ref_req && !m_ov) begin
                for (int b = 0; b < NB; b++) m_open_v[b] = 0;
            end else if (gr) begin
                m_open_v[pb[g]] = 1; m_open_row[pb[g]] = pr[g];
            end
            if (gr) begin
                m_ov = 1; m_bank = pb[g]; m_row = pr[g]; m_col = pc[g]; m_wr = pw[g];
                m_port = g; m_hit = hitv[g]; m_rr = (g + 1) % N;
                glog.push_back(g);
            end else if (out_ready) begin
                m_ov = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic setp(input int pi, input bit v, input int bank, input int row);
        req_valid[pi]            = v;
        req_bank[pi*BW +: BW]    = bank[BW-1:0];
        req_row[pi*RW +: RW]     = row[RW-1:0];
        req_col[pi*CW +: CW]     = CW'(row + pi);
        req_write[pi]            = pi[0];
    endtask

    int rr_seq [5]  = '{0, 1, 2, 3, 0};
    int rr_bank [4] = '{0, 1, 3, 4};
    int rr_row [4]  = '{'h100, 'h101, 'h102, 'h103};
    int st_seq [4]  = '{0, 1, 0, 2};
    int st_hit [4]  = '{1, 1, 1, 0};

    initial begin
        model_reset();
        rst_n = 0; req_valid = '0; req_bank = '0; req_row = '0; req_col = '0; req_write = '0;
        out_ready = 1; ref_req = 0;
        repeat (2) cyc();
        rst_n = 1;
        #1;
        chk("lit_reset_valid", out_valid, 0);
        chk("lit_reset_ready", req_ready, 0);

        // Round-robin; each port moves to a new row after its grant so no row hits occur
        for (int i = 0; i < N; i++) setp(i, 1, rr_bank[i], rr_row[i]);
        glog.delete();
        for (int i = 0; i < 5; i++) begin
            #1 chk("lit_rr_ready", req_ready, 1 << rr_seq[i]);
            cyc();
            chk("lit_rr_valid", out_valid, 1);
            chk("lit_rr_port", out_port, rr_seq[i]);
            chk("lit_rr_hit", out_row_hit, 0);
            rr_row[rr_seq[i]] += 'h100;
            setp(rr_seq[i], 1, rr_bank[rr_seq[i]], rr_row[rr_seq[i]]);
        end
        chk("lit_model_rr_len", glog.size(), 5);
        for (int i = 0; i < 5; i++) chk("lit_model_rr_seq", glog[i], rr_seq[i]);
        for (int i = 0; i < N; i++) setp(i, 0, 0, 0);
        cyc(); cyc();

        // Row hit: port 3 beats port 1 despite rr_ptr=1
        setp(0, 1, 2, 'h10);
        #1 chk("lit_hit_first_ready", req_ready, 4'b0001);
        cyc();
        setp(0, 0, 2, 'h10); setp(1, 1, 2, 'h20); setp(3, 1, 2, 'h10);
        #1 chk("lit_hit_ready", req_ready, 4'b1000);
        cyc();
        chk("lit_hit_port", out_port, 3);
        chk("lit_hit_flag", out_row_hit, 1);
        setp(1, 0, 0, 0); setp(3, 0, 0, 0);
        cyc();

        // Backpressure
        out_ready = 0;
        setp(0, 1, 6, 'h60); setp(1, 1, 7, 'h70);
        #1 chk("lit_bp_first_ready", req_ready, 4'b0001);
        cyc();
        setp(0, 0, 6, 'h60);
        repeat (5) begin
            #1 chk("lit_bp_ready", req_ready, 0);
            cyc();
            chk("lit_bp_port", out_port, 0);
            chk("lit_bp_row", out_row, 'h60);
        end
        out_ready = 1;
        #1 chk("lit_bp_release_ready", req_ready, 4'b0010);
        cyc();
        chk("lit_bp_nobubble_valid", out_valid, 1);
        chk("lit_bp_nobubble_port", out_port, 1);
        setp(1, 0, 0, 0);
        cyc();
        chk("lit_bp_drained", out_valid, 0);

        // Starvation: port 2 misses while ports 0 and 1 hit bank 2
        setp(0, 1, 2, 'h10); setp(1, 1, 2, 'h10); setp(2, 1, 5, 'h50);
        for (int i = 0; i < 4; i++) begin
            #1 chk("lit_starve_ready", req_ready, 1 << st_seq[i]);
            cyc();
            chk("lit_starve_port", out_port, st_seq[i]);
            chk("lit_starve_hit", out_row_hit, st_hit[i]);
        end
        for (int i = 0; i < N; i++) setp(i, 0, 0, 0);
        cyc();

        // Refresh drains the output, blocks grants, and forgets open rows
        out_ready = 0;
        setp(0, 1, 2, 'h10);
        #1 chk("lit_ref_pre_ready", req_ready, 4'b0001);
        cyc();
        setp(0, 0, 2, 'h10);
        ref_req = 1;
        repeat (2) begin
            #1 chk("lit_ref_ack_held", ref_ack, 0);
            cyc();
        end
        out_ready = 1;
        #1 chk("lit_ref_ack_draining", ref_ack, 0);
        cyc();
        chk("lit_ref_ack_drained", ref_ack, 1);
        setp(0, 1, 2, 'h10);
        #1 chk("lit_ref_no_grant", req_ready, 0);
        cyc(); cyc();
        ref_req = 0;
        #1 chk("lit_ref_after_ready", req_ready, 4'b0001);
        cyc();
        chk("lit_ref_after_hit", out_row_hit, 0);
        setp(0, 0, 0, 0);
        cyc();

        // Reset in the middle of backpressure
        out_ready = 0;
        setp(0, 1, 2, 'h10);
        #1 chk("lit_rst_pre_ready", req_ready, 4'b0001);
        cyc();
        setp(1, 1, 6, 'h66);
        rst_n = 0;
        #1 chk("lit_rst_mid_valid", out_valid, 0);
        chk("lit_rst_mid_ready", req_ready, 0);
        cyc();
        chk("lit_rst_hold_ready", req_ready, 0);
        rst_n = 1;
        out_ready = 1;
        setp(0, 1, 4, 'h44); setp(1, 1, 2, 'h10);
        #1 chk("lit_rst_tie_ready", req_ready, 4'b0001);
        cyc();
        chk("lit_rst_tie_port", out_port, 0);
        setp(0, 0, 0, 0);
        #1 chk("lit_rst_second_ready", req_ready, 4'b0010);
        cyc();
        chk("lit_rst_shadow_cleared", out_row_hit, 0);
        setp(1, 0, 0, 0);
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/openddr_req_arbiter.md
Name: openddr_req_arbiter

Overview:
- Multi-port request arbiter placed in front of openddr_scheduler.
- Selects one of NUM_PORTS client requests per cycle and holds it in a one-entry output register for the scheduler.
- Priority order: starved ports first, then row hits against a shadow open-row table, then round-robin.
- Blocks new grants and drains its output while a refresh is requested.

Parameters:
- NUM_PORTS, 4, number of requesters (power of 2, 2..8).
- BANK_WIDTH, 3, bank address width.
- ROW_WIDTH, 16, row address width.
- COL_WIDTH, 10, column address width.
- AGE_LIMIT, 15, wait cycles before a port is treated as starved (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port grant; one-hot or zero
- req_bank  in  NUM_PORTS*BANK_WIDTH  flattened; port p occupies [p*BANK_WIDTH +: BANK_WIDTH]
- req_row  in  NUM_PORTS*ROW_WIDTH  flattened, same packing rule
- req_col  in  NUM_PORTS*COL_WIDTH  flattened, same packing rule
- req_write  in  NUM_PORTS  1 = write, 0 = read
- out_valid  out  1  registered request valid to scheduler
- out_ready  in  1  scheduler accepts the output
- out_bank / out_row / out_col  out  BANK_WIDTH / ROW_WIDTH / COL_WIDTH  registered request address
- out_write  out  1  registered direction
- out_port  out  $clog2(NUM_PORTS)  index of the granted port
- out_row_hit  out  1  request hit the shadow open row at grant time
- ref_req  in  1  refresh pending (level)
- ref_ack  out  1  arbiter drained; refresh may proceed

Behaviour:
- Reset: all outputs 0; out registers 0; shadow table invalid; age counters 0; rr_ptr 0.
- Arbitration enable: arb_en = !ref_req && (!out_valid || out_ready).
- Grant: combinational in the same cycle as the request. req_ready[g] = 1 only for the winner g, and only when arb_en is high and some req_valid is set.
- Handshake: a transfer occurs when req_valid[g] && req_ready[g].
- Latency: the granted request appears on out_* on the next edge, with out_valid=1.
- Output register: holds while out_valid && !out_ready. out_valid clears when out_ready is high and no new grant occurs. If out_ready is high and a grant occurs in the same cycle, the register reloads with no bubble.
- Priority (first non-empty class wins). Within a class, search starts at rr_ptr, ascending, modulo NUM_PORTS:
  1. valid ports with age == AGE_LIMIT;
  2. valid ports whose bank is open in the shadow table with a matching row;
  3. all valid ports.
- rr_ptr: set to (g+1) mod NUM_PORTS on every grant.
- Age counters, per port:
  - reset to 0 when req_valid is low or the port is granted;
  - increment, saturating at AGE_LIMIT, when valid, arb_en is high, and the port is not granted;
  - hold when arb_en is low.
- Shadow table: on a grant, open_valid[bank] <= 1 and open_row[bank] <= row. out_row_hit is captured from the class-2 match for the winner.
- Refresh:
  - ref_ack = ref_req && !out_valid (combinational).
  - While ref_ack is high, all open_valid are cleared every cycle, because refresh implies all banks precharged.
  - No grants occur while ref_req is high. Ages hold.
- Simultaneous events:
  - ref_req rising in the same cycle as a potential grant: the grant is suppressed.
  - Grant to a bank that is already open with a different row: the shadow entry is overwritten.
- Invalid client behaviour: deasserting req_valid without a grant is permitted; the age for that port resets.
- Reset mid-operation: the pending output is discarded, the shadow table is invalidated, and no req_ready is asserted during reset.

Decomposition:
- Additions to openddr_pkg:
  - constant ARB_AGE_LIMIT_DEF = 15;
  - typedef arb_req_t (bank, row, col, write), used for the output register and the per-port unpacked view.
- Sub-module openddr_rr_picker (params N):
  - inputs mask[N] and ptr;
  - outputs found and idx, the first set bit at or after ptr, with wrap.
  - Instanced three times, once per priority class; a final mux selects the class.

Test Plan:
- Round-robin: ports 0–3 valid, distinct banks, out_ready=1. Expected grant order 0,1,2,3,0; out_valid is high one cycle after each grant; out_row_hit=0 on the first four.
- Row hit: port 0 granted bank 2 row 0x0010. Next cycle, port 1 requests bank 2 row 0x0020 and port 3 requests bank 2 row 0x0010, with rr_ptr=1. Port 3 wins with out_row_hit=1.
- Backpressure: out_ready=0 for 5 cycles with ports valid. Expected no req_ready, out_* stable; on out_ready=1, the next grant occurs in the same cycle with no bubble.
- Starvation: AGE_LIMIT=3. Port 2 misses bank 5 while ports 0 and 1 keep hitting. After 3 lost cycles, port 2 is granted despite the hits.
- Refresh: ref_req asserted while out_valid=1 and out_ready=0. Expected ref_ack=0 until out_ready drains the output, then ref_ack=1 with no grants. After ref_req drops, a repeat of the previous row reports out_row_hit=0.
- Reset: rst_n pulsed low mid-backpressure. Expected out_valid=0, req_ready=0, rr_ptr=0 (port 0 wins the next tie), shadow table cleared.
